// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types for the data memory arbiter
package dm_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RWAIT
   } state_e;

   typedef enum logic {
      REQ_CPU,
      REQ_DBG
   } req_e;

   localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/datamem_arbiter.sv
// rtl/datamem_arbiter.sv - cpu/dbg arbiter in front of the single-port data memory
module datamem_arbiter
   import dm_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  cpu_req_i,
   input  logic                  cpu_we_i,
   input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
   input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
   output logic                  cpu_gnt_o,
   output logic                  cpu_rvalid_o,
   output logic [DATA_WIDTH-1:0] cpu_rdata_o,
   output logic                  cpu_stall_o,

   input  logic                  dbg_req_i,
   input  logic                  dbg_we_i,
   input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
   input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
   output logic                  dbg_gnt_o,
   output logic                  dbg_rvalid_o,
   output logic [DATA_WIDTH-1:0] dbg_rdata_o,

   output logic                  mem_writemem_o,
   output logic                  mem_readmem_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_data_o,
   input  logic [DATA_WIDTH-1:0] mem_q_i
);

   localparam logic [STARVE_CNT_W-1:0] LP_LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

   state_e                  r_state;
   state_e                  w_state_nxt;
   req_e                    r_winner;
   logic                    r_we;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [STARVE_CNT_W-1:0] r_starve_cnt;
   logic [DATA_WIDTH-1:0]   r_cpu_rdata;
   logic [DATA_WIDTH-1:0]   r_dbg_rdata;
   logic                    r_cpu_rvalid;
   logic                    r_dbg_rvalid;

   logic                    w_any_req;
   logic                    w_pick_dbg;
   logic                    w_cpu_gnt;
   logic                    w_dbg_gnt;

   assign w_any_req  = cpu_req_i | dbg_req_i;
   // dbg wins when cpu is idle, or when it has waited through LP_LIMIT cpu grants
   assign w_pick_dbg = ~cpu_req_i | (dbg_req_i & (r_starve_cnt == LP_LIMIT));

   always_comb begin
      w_state_nxt    = r_state;
      w_cpu_gnt      = 1'b0;
      w_dbg_gnt      = 1'b0;
      mem_writemem_o = 1'b0;
      mem_readmem_o  = 1'b0;
      mem_addr_o     = '0;
      mem_data_o     = '0;
      case (r_state)
         IDLE: begin
            if (w_any_req) w_state_nxt = ISSUE;
         end
         ISSUE: begin
            mem_addr_o     = r_addr;
            mem_writemem_o = r_we;
            mem_readmem_o  = ~r_we;
            if (r_we) mem_data_o = r_wdata;
            w_cpu_gnt      = (r_winner == REQ_CPU);
            w_dbg_gnt      = (r_winner == REQ_DBG);
            w_state_nxt    = r_we ? IDLE : RWAIT;
         end
         RWAIT: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_winner     <= REQ_CPU;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_starve_cnt <= '0;
         r_cpu_rdata  <= '0;
         r_dbg_rdata  <= '0;
         r_cpu_rvalid <= 1'b0;
         r_dbg_rvalid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cpu_rvalid <= 1'b0;
         r_dbg_rvalid <= 1'b0;

         if (r_state == IDLE && w_any_req) begin
            r_winner <= w_pick_dbg ? REQ_DBG : REQ_CPU;
            r_we     <= w_pick_dbg ? dbg_we_i    : cpu_we_i;
            r_addr   <= w_pick_dbg ? dbg_addr_i  : cpu_addr_i;
            r_wdata  <= w_pick_dbg ? dbg_wdata_i : cpu_wdata_i;
         end

         if (r_state == RWAIT) begin
            if (r_winner == REQ_CPU) begin
               r_cpu_rdata  <= mem_q_i;
               r_cpu_rvalid <= 1'b1;
            end else begin
               r_dbg_rdata  <= mem_q_i;
               r_dbg_rvalid <= 1'b1;
            end
         end

         if (!dbg_req_i || w_dbg_gnt) begin
            r_starve_cnt <= '0;
         end else if (w_cpu_gnt && r_starve_cnt != LP_LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
         end
      end
   end

   assign cpu_gnt_o    = w_cpu_gnt;
   assign dbg_gnt_o    = w_dbg_gnt;
   assign cpu_rvalid_o = r_cpu_rvalid;
   assign dbg_rvalid_o = r_dbg_rvalid;
   assign cpu_rdata_o  = r_cpu_rdata;
   assign dbg_rdata_o  = r_dbg_rdata;

   // a cpu read keeps the pipeline held from request until its data returns
   assign cpu_stall_o = (cpu_req_i & ~w_cpu_gnt)
                      | ((r_winner == REQ_CPU) & (((r_state == ISSUE) & ~r_we) | (r_state == RWAIT)));

endmodule

// File: tb/tb_datamem_arbiter.sv
// tb/tb_datamem_arbiter.sv - directed bench for datamem_arbiter
module tb_datamem_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cpu_req_i, cpu_we_i, dbg_req_i, dbg_we_i;
   logic [7:0] cpu_addr_i, cpu_wdata_i, dbg_addr_i, dbg_wdata_i;
   logic       cpu_gnt_o, cpu_rvalid_o, cpu_stall_o;
   logic       dbg_gnt_o, dbg_rvalid_o;
   logic [7:0] cpu_rdata_o, dbg_rdata_o;
   logic       mem_writemem_o, mem_readmem_o;
   logic [7:0] mem_addr_o, mem_data_o, mem_q;

   logic [7:0] mem [256];
   bit         written [256];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   datamem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .STARVE_LIMIT(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cpu_req_i      (cpu_req_i),
      .cpu_we_i       (cpu_we_i),
      .cpu_addr_i     (cpu_addr_i),
      .cpu_wdata_i    (cpu_wdata_i),
      .cpu_gnt_o      (cpu_gnt_o),
      .cpu_rvalid_o   (cpu_rvalid_o),
      .cpu_rdata_o    (cpu_rdata_o),
      .cpu_stall_o    (cpu_stall_o),
      .dbg_req_i      (dbg_req_i),
      .dbg_we_i       (dbg_we_i),
      .dbg_addr_i     (dbg_addr_i),
      .dbg_wdata_i    (dbg_wdata_i),
      .dbg_gnt_o      (dbg_gnt_o),
      .dbg_rvalid_o   (dbg_rvalid_o),
      .dbg_rdata_o    (dbg_rdata_o),
      .mem_writemem_o (mem_writemem_o),
      .mem_readmem_o  (mem_readmem_o),
      .mem_addr_o     (mem_addr_o),
      .mem_data_o     (mem_data_o),
      .mem_q_i        (mem_q)
   );

   // datamem stand-in: unwritten locations read back as addr ^ 0x5A
   always @(posedge clk) begin
      if (mem_writemem_o) begin
         mem[mem_addr_o]     <= mem_data_o;
         written[mem_addr_o] <= 1'b1;
      end
      if (mem_readmem_o)
         mem_q <= written[mem_addr_o] ? mem[mem_addr_o] : (mem_addr_o ^ 8'h5A);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cpu_gnt"},  cpu_gnt_o, 0);
      chk({tag, "_dbg_gnt"},  dbg_gnt_o, 0);
      chk({tag, "_cpu_rv"},   cpu_rvalid_o, 0);
      chk({tag, "_dbg_rv"},   dbg_rvalid_o, 0);
      chk({tag, "_cpu_rd"},   cpu_rdata_o, 0);
      chk({tag, "_dbg_rd"},   dbg_rdata_o, 0);
      chk({tag, "_stall"},    cpu_stall_o, 0);
      chk({tag, "_wr"},       mem_writemem_o, 0);
      chk({tag, "_rd"},       mem_readmem_o, 0);
      chk({tag, "_addr"},     mem_addr_o, 0);
      chk({tag, "_data"},     mem_data_o, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0;
      dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = 0; dbg_wdata_i = 0;
      cyc();
      cyc();
      #3;
      chk_all_zero("reset");
      rst_n = 1'b1;

      // cpu write 0x10 <- 0xA5
      cyc();
      cpu_req_i = 1; cpu_we_i = 1; cpu_addr_i = 8'h10; cpu_wdata_i = 8'hA5;
      #3;
      chk("wr_n_stall", cpu_stall_o, 1);
      chk("wr_n_gnt",   cpu_gnt_o, 0);
      chk("wr_n_we",    mem_writemem_o, 0);
      cyc();
      #3;
      chk("wr_n1_we",    mem_writemem_o, 1);
      chk("wr_n1_re",    mem_readmem_o, 0);
      chk("wr_n1_addr",  mem_addr_o, 8'h10);
      chk("wr_n1_data",  mem_data_o, 8'hA5);
      chk("wr_n1_gnt",   cpu_gnt_o, 1);
      chk("wr_n1_stall", cpu_stall_o, 0);
      cpu_req_i = 0;
      cyc();
      #3;
      chk("wr_n2_we",    mem_writemem_o, 0);
      chk("wr_n2_stall", cpu_stall_o, 0);

      // cpu read 0x10
      cyc();
      cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 8'h10; cpu_wdata_i = 8'hFF;
      #3;
      chk("rd_n_stall", cpu_stall_o, 1);
      cyc();
      #3;
      chk("rd_n1_re",    mem_readmem_o, 1);
      chk("rd_n1_we",    mem_writemem_o, 0);
      chk("rd_n1_addr",  mem_addr_o, 8'h10);
      chk("rd_n1_data",  mem_data_o, 0);
      chk("rd_n1_gnt",   cpu_gnt_o, 1);
      chk("rd_n1_stall", cpu_stall_o, 1);
      cpu_req_i = 0;
      cyc();
      #3;
      chk("rd_n2_stall", cpu_stall_o, 1);
      chk("rd_n2_re",    mem_readmem_o, 0);
      chk("rd_n2_rv",    cpu_rvalid_o, 0);
      cyc();
      #3;
      chk("rd_n3_rv",    cpu_rvalid_o, 1);
      chk("rd_n3_rdata", cpu_rdata_o, 8'hA5);
      chk("rd_n3_stall", cpu_stall_o, 0);

      // dbg read 0x3F alone
      cyc();
      dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 8'h3F;
      #3;
      chk("rd_n4_rv",     cpu_rvalid_o, 0);
      chk("rd_n4_hold",   cpu_rdata_o, 8'hA5);
      chk("dbg_n_stall",  cpu_stall_o, 0);
      chk("dbg_n_gnt",    dbg_gnt_o, 0);
      cyc();
      #3;
      chk("dbg_n1_gnt",   dbg_gnt_o, 1);
      chk("dbg_n1_cgnt",  cpu_gnt_o, 0);
      chk("dbg_n1_re",    mem_readmem_o, 1);
      chk("dbg_n1_addr",  mem_addr_o, 8'h3F);
      chk("dbg_n1_stall", cpu_stall_o, 0);
      dbg_req_i = 0;
      cyc();
      #3;
      chk("dbg_n2_stall", cpu_stall_o, 0);
      chk("dbg_n2_rv",    dbg_rvalid_o, 0);
      cyc();
      #3;
      chk("dbg_n3_rv",    dbg_rvalid_o, 1);
      chk("dbg_n3_rdata", dbg_rdata_o, 8'h65);
      chk("dbg_n3_crv",   cpu_rvalid_o, 0);
      chk("dbg_n3_stall", cpu_stall_o, 0);

      // both hold write requests: cpu x4 then dbg, repeating
      cyc();
      cpu_req_i = 1; cpu_we_i = 1; cpu_addr_i = 8'h20; cpu_wdata_i = 8'h11;
      dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 8'h30; dbg_wdata_i = 8'h22;
      #3;
      chk("starve_idle_drv", dbg_rvalid_o, 0);
      for (int g = 0; g < 10; g++) begin
         cyc();
         #3;
         if (g % 5 == 4) begin
            chk($sformatf("starve_g%0d_dgnt", g),  dbg_gnt_o, 1);
            chk($sformatf("starve_g%0d_cgnt", g),  cpu_gnt_o, 0);
            chk($sformatf("starve_g%0d_addr", g),  mem_addr_o, 8'h30);
            chk($sformatf("starve_g%0d_stall", g), cpu_stall_o, 1);
         end else begin
            chk($sformatf("starve_g%0d_cgnt", g),  cpu_gnt_o, 1);
            chk($sformatf("starve_g%0d_dgnt", g),  dbg_gnt_o, 0);
            chk($sformatf("starve_g%0d_addr", g),  mem_addr_o, 8'h20);
         end
         cyc();
      end

      // cpu read interrupted by reset in RWAIT
      dbg_req_i = 0;
      cpu_we_i = 0; cpu_addr_i = 8'h20;
      cyc();
      #3;
      chk("rst_rd_gnt", cpu_gnt_o, 1);
      chk("rst_rd_re",  mem_readmem_o, 1);
      cpu_req_i = 0;
      cyc();
      rst_n = 1'b0;
      #3;
      chk("rst_rwait_stall", cpu_stall_o, 1);
      cyc();
      rst_n = 1'b1;
      #3;
      chk_all_zero("post_rst");
      cyc();
      cpu_req_i = 1; cpu_we_i = 1; cpu_addr_i = 8'h40; cpu_wdata_i = 8'h77;
      #3;
      chk("post_rst_rv",    cpu_rvalid_o, 0);
      chk("post_rst_gnt0",  cpu_gnt_o, 0);
      chk("post_rst_stall", cpu_stall_o, 1);
      cyc();
      #3;
      chk("post_rst_gnt1", cpu_gnt_o, 1);
      chk("post_rst_we",   mem_writemem_o, 1);
      chk("post_rst_addr", mem_addr_o, 8'h40);
      chk("post_rst_data", mem_data_o, 8'h77);
      chk("post_rst_crv",  cpu_rvalid_o, 0);
      cpu_req_i = 0;

      // simultaneous requests: cpu first, dbg in the next IDLE
      cyc();
      cpu_req_i = 1; cpu_we_i = 1; cpu_addr_i = 8'h50; cpu_wdata_i = 8'h01;
      dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 8'h51; dbg_wdata_i = 8'h02;
      #3;
      chk("sim_idle_cgnt", cpu_gnt_o, 0);
      chk("sim_idle_dgnt", dbg_gnt_o, 0);
      cyc();
      #3;
      chk("sim_cgnt",  cpu_gnt_o, 1);
      chk("sim_dgnt0", dbg_gnt_o, 0);
      chk("sim_caddr", mem_addr_o, 8'h50);
      chk("sim_cdata", mem_data_o, 8'h01);
      cpu_req_i = 0;
      cyc();
      #3;
      chk("sim_idle2_dgnt", dbg_gnt_o, 0);
      cyc();
      #3;
      chk("sim_dgnt",  dbg_gnt_o, 1);
      chk("sim_cgnt0", cpu_gnt_o, 0);
      chk("sim_daddr", mem_addr_o, 8'h51);
      chk("sim_ddata", mem_data_o, 8'h02);
      dbg_req_i = 0;

      // cpu reads back the dbg-written byte
      cyc();
      cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 8'h51;
      cyc();
      #3;
      chk("rb_gnt", cpu_gnt_o, 1);
      cpu_req_i = 0;
      cyc();
      cyc();
      #3;
      chk("rb_rv",    cpu_rvalid_o, 1);
      chk("rb_rdata", cpu_rdata_o, 8'h02);
      chk("rb_drv",   dbg_rvalid_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
- Shares the single-port data memory (datamem, 8-bit address, 8-bit data) between two requesters: the pipeline MEM stage (cpu) and a debug/loader port (dbg).
- Sequences each access as a registered memory command. Write access takes one command cycle. Read access takes a command cycle, a wait cycle, then returns registered data.
- Produces the pipeline stall so fetch/regfile hold while a cpu access is not yet complete.
- CPU has fixed priority. A starvation counter forces a dbg grant periodically.

Parameters:
- ADDR_WIDTH, 8, memory address width (matches datamem ADDR_WIDTH).
- DATA_WIDTH, 8, memory data width.
- STARVE_LIMIT, 4, consecutive cpu grants allowed while dbg is pending before dbg is forced; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- cpu_req_i  in  1  cpu access request; held high until cpu_gnt_o.
- cpu_we_i  in  1  1=write, 0=read; valid with cpu_req_i.
- cpu_addr_i  in  ADDR_WIDTH  cpu address.
- cpu_wdata_i  in  DATA_WIDTH  cpu write data.
- cpu_gnt_o  out  1  one-cycle pulse; cpu command is on the memory bus this cycle.
- cpu_rvalid_o  out  1  one-cycle pulse; cpu_rdata_o valid.
- cpu_rdata_o  out  DATA_WIDTH  cpu read data.
- cpu_stall_o  out  1  pipeline stall.
- dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i  in  1/1/ADDR_WIDTH/DATA_WIDTH  same rules as cpu.
- dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o  out  1/1/DATA_WIDTH  same rules as cpu.
- mem_writemem_o  out  1  to datamem writemem.
- mem_readmem_o  out  1  to datamem readmem.
- mem_addr_o  out  ADDR_WIDTH  to datamem addr.
- mem_data_o  out  DATA_WIDTH  to datamem data.
- mem_q_i  in  DATA_WIDTH  datamem q; valid the cycle after readmem is asserted.

Behaviour:
- Reset: one clock and a synchronous active-low reset, named clk and rst_n. On any edge with rst_n=0:
  - state goes to IDLE and the starve counter clears.
  - any pending read is discarded; no rvalid is produced for it.
  - from the next cycle all outputs read 0 except cpu_stall_o, which follows its equation (cpu_req_i=1 in IDLE gives stall=1).
- States: IDLE, ISSUE, RWAIT.
- IDLE, in cycle N with at least one request:
  - latch winner id, we, addr and wdata; go to ISSUE.
  - winner is cpu if cpu_req_i=1 and not (dbg_req_i=1 and starve_cnt==STARVE_LIMIT); otherwise dbg.
- ISSUE (N+1):
  - drive mem_addr_o from latched addr.
  - write: mem_writemem_o=1, mem_data_o=wdata.
  - read: mem_readmem_o=1, mem_data_o=0.
  - assert winner's gnt_o.
  - next state: write goes to IDLE; read goes to RWAIT.
- RWAIT (N+2): capture mem_q_i into the winner's rdata register; go to IDLE.
- Read return: in cycle N+3 the winner's rvalid_o pulses for one cycle and rdata_o holds the value until that requester's next read returns.
- Latency: write occupies 2 cycles (N..N+1); read occupies 3 busy cycles with data at N+3.
- The next arbitration can happen in the IDLE cycle N+2 (write) or N+3 (read).
- Memory outputs are all 0 in IDLE and RWAIT.
- Starve counter (4 bits):
  - +1 on each cpu grant while dbg_req_i=1.
  - cleared on dbg grant or whenever dbg_req_i=0.
  - saturates at STARVE_LIMIT.
- cpu_stall_o is combinational. It is 1 when cpu_req_i=1 and cpu_gnt_o=0, or when a cpu read is latched/issued and its rvalid has not yet pulsed, i.e. RWAIT with winner cpu.
  - Stall drops in the gnt cycle for writes.
  - Stall drops in the rvalid cycle for reads.
- Requests are only sampled in IDLE; changing req/we/addr/wdata while not granted is allowed, and the values present in the arbitration cycle win.
- Dropping a request before grant is allowed: no access occurs.
- A requester whose gnt has not pulsed must not observe any side effect.
- Simultaneous requests in IDLE use the priority rule above. Only one access is ever in flight.

Decomposition:
- Package dm_arb_pkg holds:
  - state enum {IDLE, ISSUE, RWAIT}.
  - requester enum {REQ_CPU, REQ_DBG}.
  - STARVE_CNT_W=4.
- A single module; no sub-module is warranted (the starve counter is a few lines inline).

Test Plan:
- cpu write addr 0x10 data 0xA5 in cycle N, dbg idle -> N+1: mem_writemem_o=1, mem_addr_o=0x10, mem_data_o=0xA5, cpu_gnt_o=1; cpu_stall_o=1 only in cycle N.
- Then cpu read 0x10 -> readmem at N+1, cpu_rvalid_o=1 with cpu_rdata_o=0xA5 at N+3; cpu_stall_o=1 for N..N+2, 0 at N+3.
- dbg read 0x3F alone -> dbg_gnt_o at N+1, dbg_rvalid_o at N+3; cpu_stall_o stays 0 throughout.
- Both requesters held high with writes, STARVE_LIMIT=4 -> grant sequence cpu,cpu,cpu,cpu,dbg repeating; never more than 4 consecutive cpu grants.
- rst_n=0 during RWAIT of a cpu read -> no cpu_rvalid_o ever pulses for that read; next cycle all outputs 0; a new request after rst_n=1 is granted one cycle after it is seen in IDLE.
- Both request in same IDLE cycle with starve_cnt=0 -> cpu granted first; dbg granted in the following IDLE cycle if cpu_req_i drops.
